// File: rtl/shift_sink.sv
`timescale 1ns/1ps
// shift_sink
// Serial-to-parallel receiver for the {sclk, sdo, pen, clr} shift-register
// bus. The bus is asynchronous to clk and oversampled. One frame is shifted
// in MSB first while pen is low. The rising edge of pen latches the frame
// if exactly WIDTH bits arrived. Otherwise it flags a framing error.
//
// Ports
//   clk        system clock; bus oversampled on its rising edge
//   rstn       asynchronous active-low reset
//   sclk       serial shift clock (async)
//   sdo        serial data, sampled on sclk rising edges
//   pen        parallel enable: low while shifting, rising edge latches
//   clr        active-low clear of the receive shift register
//   data       last correctly sized frame (first bit in -> data[WIDTH-1])
//   data_valid one-cycle pulse when data updates
//   frame_err  one-cycle pulse when a latch sees a bit count other than WIDTH
//   frame_cnt  count of good frames, wraps 16'hFFFF -> 0
module shift_sink #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             sclk,
    input  logic             sdo,
    input  logic             pen,
    input  logic             clr,
    output logic [WIDTH-1:0] data,
    output logic             data_valid,
    output logic             frame_err,
    output logic [15:0]      frame_cnt
);

    // Counter holds 0..WIDTH+1. WIDTH+1 is the sticky "too long" value.
    localparam int CW = $clog2(WIDTH + 2);
    localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH);
    localparam logic [CW-1:0] CNT_SAT  = CW'(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, LATCH} state_e;

    // Each stage vector is {prev, sync2, sync1}.
    // Bit 1 is the synchronised level. Bit 2 is the previous copy used for edge detection.
    logic [2:0]       sclk_s_q, sclk_s_d;
    logic [2:0]       sdo_s_q,  sdo_s_d;
    logic [2:0]       pen_s_q,  pen_s_d;
    logic [2:0]       clr_s_q,  clr_s_d;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             data_valid_q, data_valid_d;
    logic             frame_err_q, frame_err_d;
    logic [15:0]      frame_cnt_q, frame_cnt_d;

    logic sclk_rise;
    logic pen_rise;
    logic pen_lvl;
    logic clr_lvl;
    logic sdo_aligned;

    assign sclk_rise   = sclk_s_q[1] & ~sclk_s_q[2];
    assign pen_rise    = pen_s_q[1]  & ~pen_s_q[2];
    assign pen_lvl     = pen_s_q[1];
    assign clr_lvl     = clr_s_q[1];
    // The third sdo stage lines the data bit up with the cycle in which sclk_rise is seen.
    assign sdo_aligned = sdo_s_q[2];

    always_comb begin
        // NOTE: every signal gets a default here, so no path can leave it unassigned and infer a latch.
        sclk_s_d     = {sclk_s_q[1:0], sclk};
        sdo_s_d      = {sdo_s_q[1:0],  sdo};
        pen_s_d      = {pen_s_q[1:0],  pen};
        clr_s_d      = {clr_s_q[1:0],  clr};
        state_d      = state_q;
        sr_d         = sr_q;
        cnt_d        = cnt_q;
        data_d       = data_q;
        data_valid_d = 1'b0;
        frame_err_d  = 1'b0;
        frame_cnt_d  = frame_cnt_q;

        if (!clr_lvl) begin
            // Clear wins over everything but reset. data and frame_cnt are kept.
            state_d = IDLE;
            sr_d    = '0;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (!pen_lvl) state_d = SHIFT;
                end
                SHIFT: begin
                    // A latch edge in the same cycle as a shift edge drops the bit.
                    if (pen_rise) begin
                        state_d = LATCH;
                    end else if (sclk_rise) begin
                        sr_d  = (sr_q << 1) | WIDTH'(sdo_aligned);
                        cnt_d = (cnt_q == CNT_SAT) ? CNT_SAT : cnt_q + CW'(1);
                    end
                end
                LATCH: begin
                    if (cnt_q == CNT_FULL) begin
                        data_d       = sr_q;
                        data_valid_d = 1'b1;
                        frame_cnt_d  = frame_cnt_q + 16'd1;
                    end else begin
                        frame_err_d  = 1'b1;
                    end
                    cnt_d   = '0;
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // NOTE: state is updated with non-blocking assignments so that all flops sample pre-edge values.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sclk_s_q     <= '0;
            sdo_s_q      <= '0;
            pen_s_q      <= '0;
            clr_s_q      <= '0;
            state_q      <= IDLE;
            sr_q         <= '0;
            cnt_q        <= '0;
            data_q       <= '0;
            data_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            frame_cnt_q  <= '0;
        end else begin
            sclk_s_q     <= sclk_s_d;
            sdo_s_q      <= sdo_s_d;
            pen_s_q      <= pen_s_d;
            clr_s_q      <= clr_s_d;
            state_q      <= state_d;
            sr_q         <= sr_d;
            cnt_q        <= cnt_d;
            data_q       <= data_d;
            data_valid_q <= data_valid_d;
            frame_err_q  <= frame_err_d;
            frame_cnt_q  <= frame_cnt_d;
        end
    end

    assign data       = data_q;
    assign data_valid = data_valid_q;
    assign frame_err  = frame_err_q;
    assign frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_shift_sink.sv
`timescale 1ns/1ps
// tb_shift_sink
// Drives one shared serial bus into a 16-bit receiver and a 64-bit receiver.
// The reference model keeps the bits sent since the last latch, clear or
// reset in a queue. At each latch it decides the expected result for each
// width from the queue length alone, and builds the expected word from the
// queued bits.
module tb_shift_sink;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        sclk = 1'b0;
    logic        sdo = 1'b0;
    logic        pen = 1'b1;
    logic        clr = 1'b1;

    logic [15:0] data16;
    logic        dv16, fe16;
    logic [15:0] fc16;
    logic [63:0] data64;
    logic        dv64, fe64;
    logic [15:0] fc64;

    int          n_tests = 0;
    int          n_fail  = 0;

    logic        bits_q[$];
    logic [15:0] exp_data16 = '0;
    logic [63:0] exp_data64 = '0;
    logic [15:0] exp_cnt16  = '0;
    logic [15:0] exp_cnt64  = '0;

    always #5 clk = ~clk;

    shift_sink #(.WIDTH(16)) u_led (
        .clk(clk), .rstn(rstn), .sclk(sclk), .sdo(sdo), .pen(pen), .clr(clr),
        .data(data16), .data_valid(dv16), .frame_err(fe16), .frame_cnt(fc16)
    );

    shift_sink #(.WIDTH(64)) u_seg (
        .clk(clk), .rstn(rstn), .sclk(sclk), .sdo(sdo), .pen(pen), .clr(clr),
        .data(data64), .data_valid(dv64), .frame_err(fe64), .frame_cnt(fc64)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) tick();
    endtask

    task automatic start_frame();
        pen = 1'b0;
        wait_cycles(5);
    endtask

    // Shift the low n bits of val, MSB first, and meet the sdo setup and hold and sclk level timing.
    task automatic shift_bits(input logic [63:0] val, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            sdo = val[i];
            wait_cycles(3);
            sclk = 1'b1;
            wait_cycles(3);
            sclk = 1'b0;
            bits_q.push_back(val[i]);
        end
        wait_cycles(3);
    endtask

    task automatic check_outputs(input string tag);
        check({tag, "/data16"}, {48'd0, data16}, {48'd0, exp_data16});
        check({tag, "/data64"}, data64, exp_data64);
        check({tag, "/cnt16"},  {48'd0, fc16}, {48'd0, exp_cnt16});
        check({tag, "/cnt64"},  {48'd0, fc64}, {48'd0, exp_cnt64});
    endtask

    // Raise pen, then check that the pulses appear exactly on the 4th edge and last one cycle.
    task automatic latch_check(input string tag);
        int          n;
        logic        good16, good64;
        logic [63:0] word;
        n      = bits_q.size();
        good16 = (n == 16);
        good64 = (n == 64);
        word   = '0;
        foreach (bits_q[i]) word = {word[62:0], bits_q[i]};
        if (good16) begin
            exp_data16 = word[15:0];
            exp_cnt16  = exp_cnt16 + 16'd1;
        end
        if (good64) begin
            exp_data64 = word;
            exp_cnt64  = exp_cnt64 + 16'd1;
        end
        bits_q.delete();

        pen = 1'b1;
        wait_cycles(3);
        check({tag, "/early"}, {60'd0, dv16, fe16, dv64, fe64}, 64'd0);
        tick();
        check({tag, "/pulse16"}, {62'd0, dv16, fe16}, {62'd0, good16, ~good16});
        check({tag, "/pulse64"}, {62'd0, dv64, fe64}, {62'd0, good64, ~good64});
        check_outputs(tag);
        tick();
        check({tag, "/after"}, {60'd0, dv16, fe16, dv64, fe64}, 64'd0);
        wait_cycles(3);
    endtask

    task automatic model_reset();
        bits_q.delete();
        exp_data16 = '0;
        exp_data64 = '0;
        exp_cnt16  = '0;
        exp_cnt64  = '0;
    endtask

    initial begin
        int lens[6];
        lens = '{16, 64, 15, 17, 16, 64};

        // Reset state
        #3;
        check({"reset", "/pulses"}, {60'd0, dv16, fe16, dv64, fe64}, 64'd0);
        check_outputs("reset");
        wait_cycles(2);
        rstn = 1'b1;
        wait_cycles(4);

        // Good frame
        start_frame();
        shift_bits(64'hA5C3, 16);
        latch_check("good_a5c3");

        // Short frame
        start_frame();
        shift_bits({32'd0, $urandom}, 15);
        latch_check("short");

        // Long frame followed by a good frame
        start_frame();
        shift_bits({32'd0, $urandom}, 17);
        latch_check("long");
        start_frame();
        shift_bits(64'h0001, 16);
        latch_check("good_0001");

        // Clear mid-frame
        start_frame();
        shift_bits({32'd0, $urandom}, 8);
        clr = 1'b0;
        wait_cycles(4);
        clr = 1'b1;
        bits_q.delete();
        wait_cycles(5);
        shift_bits(64'hFFFF, 16);
        latch_check("after_clr");

        // Async reset mid-frame
        start_frame();
        shift_bits({32'd0, $urandom}, 5);
        #2;
        rstn = 1'b0;
        #1;
        model_reset();
        check({"async_rst", "/pulses"}, {60'd0, dv16, fe16, dv64, fe64}, 64'd0);
        check_outputs("async_rst");
        tick();
        rstn = 1'b1;
        wait_cycles(5);
        shift_bits(64'h1234, 16);
        latch_check("post_rst_1234");

        // Segment width and counter wrap
        force u_seg.frame_cnt_q = 16'hFFFF;
        tick();
        release u_seg.frame_cnt_q;
        tick();
        exp_cnt64 = 16'hFFFF;
        check("preload/cnt64", {48'd0, fc64}, {48'd0, exp_cnt64});
        start_frame();
        shift_bits(64'h0123_4567_89AB_CDEF, 64);
        latch_check("seg_wrap");

        // Randomised frames of mixed lengths
        for (int k = 0; k < 6; k++) begin
            start_frame();
            shift_bits({$urandom, $urandom}, lens[k]);
            latch_check($sformatf("rand%0d_len%0d", k, lens[k]));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
